// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//   Instruction fetch/decode front end. Holds the PC, issues single-word
//   reads to the instruction RAM (never more than one in flight), buffers
//   returned words in a DEPTH-entry prefetch FIFO and splits the head word
//   into Cond/OpCode/S/destination/source_2/source_1/IV fields.
//
//   Optional build macro: PERF_CNT_EN
//     When defined, adds Fetch_Count (accepted pops) and Flush_Count
//     (redirects) output counters. When undefined they are absent.
//
//   Handshake: the consumer side is strict valid/ready. Dec_Valid never
//   depends on Dec_Ready; a transfer happens on a posedge where both are
//   high. Once Dec_Valid is high the head entry stays stable until it is
//   popped or a Redirect/reset flushes the FIFO.
//
//   dbg_state exposes the fetch FSM state (0=FETCH, 1=WAIT, 2=DRAIN).
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              Mem_Enable,
    output logic              Mem_RW,
    output logic [ADDR_W-1:0] Mem_Address,
    input  logic [DATA_W-1:0] Mem_Data,
    input  logic              Mem_Valid,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_Addr,
    output logic              Dec_Valid,
    input  logic              Dec_Ready,
    output logic [ADDR_W-1:0] Instr_PC,
    output logic [3:0]        Cond,
    output logic [3:0]        OpCode,
    output logic              S,
    output logic [3:0]        destination,
    output logic [3:0]        source_2,
    output logic [3:0]        source_1,
    output logic [4:0]        IV,
    output logic [1:0]        dbg_state
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       Fetch_Count,
    output logic [31:0]       Flush_Count
`endif
);

    // Only bits [31:6] of an instruction carry decoded fields, so only
    // those are kept in the prefetch buffer.
    localparam int FLD_W = 26;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FLD_W-1:0]   fld_q  [DEPTH];
    logic [FLD_W-1:0]   fld_d  [DEPTH];
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [ADDR_W-1:0]  addr_d [DEPTH];
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;

    logic               outstanding;
    logic [CNT_W-1:0]   free_slots;
    logic               issue;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [FLD_W-1:0]   head_fld;

    // Bits of the returned word outside [31:6] are intentionally ignored.
    logic               unused_mem_bits;
    assign unused_mem_bits = ^Mem_Data;

    // Shared status terms used by the FSM and the datapath.
    always_comb begin
        outstanding = (state_q != ST_FETCH);
        free_slots  = CNT_W'(DEPTH) - count_q - CNT_W'(outstanding);
        head_valid  = (count_q != '0);
        push        = (state_q == ST_WAIT) && Mem_Valid && !Redirect;
        pop         = head_valid && !Redirect && Dec_Ready;
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. Redirect wins over the normal flow; a read still
    // in flight after a redirect must be drained before fetching resumes.
    always_comb begin
        state_d = state_q;
        if (Redirect) begin
            state_d = (outstanding && !Mem_Valid) ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: if (issue)     state_d = ST_WAIT;
                ST_WAIT:  if (Mem_Valid) state_d = ST_FETCH;
                ST_DRAIN: if (Mem_Valid) state_d = ST_FETCH;
                default:                 state_d = ST_FETCH;
            endcase
        end
    end

    // FSM outputs: a single-cycle read strobe whenever a slot is free.
    // Reset gating keeps a request from leaking out of the reset cycle.
    always_comb begin
        issue       = Reset && !Redirect && (state_q == ST_FETCH) && (free_slots != '0);
        Mem_Enable  = issue;
        Mem_RW      = 1'b0;
        Mem_Address = pc_q;
        dbg_state   = state_q;
    end

    // PC, request address and FIFO pointer/storage next-state.
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fld_d      = fld_q;
        addr_d     = addr_q;

        if (Redirect) begin
            pc_d     = Redirect_Addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + 1'b1;
                req_addr_d = pc_q;
            end
            if (push) begin
                fld_d[wr_ptr_q]  = Mem_Data[31:6];
                addr_d[wr_ptr_q] = req_addr_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count_q so no reset is needed.
    always_ff @(posedge Clk) begin
        fld_q  <= fld_d;
        addr_q <= addr_d;
    end

    // Combinational decode of the FIFO head; fields read as zero when empty.
    always_comb begin
        head_fld    = fld_q[rd_ptr_q];
        Dec_Valid   = head_valid && !Redirect;
        Instr_PC    = '0;
        Cond        = '0;
        OpCode      = '0;
        S           = 1'b0;
        destination = '0;
        source_2    = '0;
        source_1    = '0;
        IV          = '0;
        if (head_valid) begin
            Instr_PC    = addr_q[rd_ptr_q];
            Cond        = head_fld[25:22];
            OpCode      = head_fld[21:18];
            S           = head_fld[17];
            destination = head_fld[16:13];
            source_2    = head_fld[12:9];
            source_1    = head_fld[8:5];
            IV          = head_fld[4:0];
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Performance counter next-state: accepted pops and redirects, wrapping.
    always_comb begin
        fetch_count_d = fetch_count_q + (pop ? 32'd1 : 32'd0);
        flush_count_d = flush_count_q + (Redirect ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign Fetch_Count = fetch_count_q;
    assign Flush_Count = flush_count_q;
`endif

endmodule
